// File: rtl/up_bus_pkg.sv
// Shared constants, state type and window-decode helper for the up_* register target.
package up_bus_pkg;

    localparam logic [3:0] OFF_ID       = 4'd0;
    localparam logic [3:0] OFF_SCRATCH  = 4'd1;
    localparam logic [3:0] OFF_CONTROL  = 4'd2;
    localparam logic [3:0] OFF_STATUS   = 4'd3;
    localparam logic [3:0] OFF_ACC_CNT  = 4'd4;
    localparam logic [3:0] OFF_DROP_CNT = 4'd5;

    localparam logic [31:0] READ_MISS = 32'hDEAD_BEEF;

    localparam int unsigned WAIT_CYCLES_MIN = 1;
    localparam int unsigned WAIT_CYCLES_MAX = 15;

    typedef enum logic {StIdle, StBusy} state_e;

    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/up_sticky_status.sv
// Sticky event bits: set by single-cycle pulses, cleared by write-one-to-clear; set wins.
module up_sticky_status #(
    parameter int unsigned STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAT_W-1:0] set,
    input  logic              clr_en,
    input  logic [STAT_W-1:0] clr_mask,
    output logic [STAT_W-1:0] status
);

    logic [STAT_W-1:0] status_d;

    always_comb begin
        status_d = status;
        if (clr_en) begin
            status_d = status_d & ~clr_mask;
        end
        status_d = status_d | set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else begin
            status <= status_d;
        end
    end

endmodule

// File: rtl/up_reg_slave.sv
// up_* bus target: window decode, fixed-length wait stall, and a small ID/scratch/control/
// status/counter register file.
module up_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFC0,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h4554_4831,
    parameter int unsigned STAT_W      = 8
) (
    input  logic              up_clk,
    input  logic              up_rst_n,
    input  logic              up_wr,
    input  logic              up_rd,
    input  logic [31:0]       up_addr,
    input  logic [31:0]       up_data_wr,
    output logic [31:0]       up_data_rd,
    output logic              up_wait,
    output logic [7:0]        ctrl_out,
    input  logic [STAT_W-1:0] status_in,
    output logic              irq
);

    import up_bus_pkg::*;

    localparam int unsigned WaitEff =
        (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN :
        (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam logic [3:0] WaitLoad = 4'(WaitEff - 1);

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        op_wr_q;
    logic [3:0]  op_off_q;
    logic [31:0] op_data_q;

    logic [31:0] scratch_q;
    logic [15:0] ctrl_q;
    logic [31:0] acc_cnt_q;
    logic [15:0] drop_cnt_q;
    logic [STAT_W-1:0] status;

    logic        strobe;
    logic        hit;
    logic        accept;
    logic        drop;
    logic        commit;
    logic        wr_commit;
    logic [31:0] rd_mux;

    assign strobe    = up_wr | up_rd;
    assign hit       = addr_in_window(up_addr, BASE_ADDR, ADDR_MASK);
    assign accept    = (state_q == StIdle) && hit && (up_wr ^ up_rd);
    // Anything arriving while busy is lost, as is an ambiguous wr+rd aimed at us.
    assign drop      = ((state_q == StBusy) && strobe) ||
                       ((state_q == StIdle) && hit && up_wr && up_rd);
    assign commit    = (state_q == StBusy) && (wait_cnt_q == 4'd0);
    assign wr_commit = commit && op_wr_q;

    assign ctrl_out  = ctrl_q[7:0];

    always_comb begin
        rd_mux = READ_MISS;
        case (op_off_q)
            OFF_ID:       rd_mux = ID_VALUE;
            OFF_SCRATCH:  rd_mux = scratch_q;
            OFF_CONTROL:  rd_mux = {16'h0000, ctrl_q};
            OFF_STATUS:   rd_mux = 32'(status);
            OFF_ACC_CNT:  rd_mux = acc_cnt_q;
            OFF_DROP_CNT: rd_mux = {16'h0000, drop_cnt_q};
            default:      ;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            op_wr_q    <= 1'b0;
            op_off_q   <= 4'd0;
            op_data_q  <= 32'h0;
            up_wait    <= 1'b0;
            up_data_rd <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StBusy;
                        wait_cnt_q <= WaitLoad;
                        op_wr_q    <= up_wr;
                        op_off_q   <= up_addr[5:2];
                        op_data_q  <= up_data_wr;
                        up_wait    <= 1'b1;
                    end
                end
                StBusy: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                        up_wait <= 1'b0;
                        if (!op_wr_q) begin
                            up_data_rd <= rd_mux;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n) begin
            scratch_q  <= 32'h0;
            ctrl_q     <= 16'h0;
            acc_cnt_q  <= 32'h0;
            drop_cnt_q <= 16'h0;
            irq        <= 1'b0;
        end else begin
            if (wr_commit && (op_off_q == OFF_SCRATCH)) begin
                scratch_q <= op_data_q;
            end
            if (wr_commit && (op_off_q == OFF_CONTROL)) begin
                ctrl_q <= op_data_q[15:0];
            end
            if (commit) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            irq <= |(status & ctrl_q[8 +: STAT_W]);
        end
    end

    up_sticky_status #(
        .STAT_W (STAT_W)
    ) u_status (
        .clk      (up_clk),
        .rst_n    (up_rst_n),
        .set      (status_in),
        .clr_en   (wr_commit && (op_off_q == OFF_STATUS)),
        .clr_mask (op_data_q[STAT_W-1:0]),
        .status   (status)
    );

endmodule

// File: tb/tb_up_reg_slave.sv
// Self-checking bench for up_reg_slave: vector table plus multi-cycle corner sequences.
module tb_up_reg_slave;

    localparam int STAT_W   = 8;
    localparam int WAIT_CYC = 2;
    localparam logic [31:0] ID = 32'h4554_4831;
    localparam logic [31:0] MISS = 32'hDEAD_BEEF;

    logic              up_clk = 1'b0;
    logic              up_rst_n = 1'b0;
    logic              up_wr = 1'b0;
    logic              up_rd = 1'b0;
    logic [31:0]       up_addr = 32'h0;
    logic [31:0]       up_data_wr = 32'h0;
    logic [31:0]       up_data_rd;
    logic              up_wait;
    logic [7:0]        ctrl_out;
    logic [STAT_W-1:0] status_in = '0;
    logic              irq;

    int n_cmp = 0;
    int n_fail = 0;
    int m_acc = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_wait;
        logic [7:0]  exp_ctrl;
    } vec_t;

    vec_t vecs[18];

    up_reg_slave #(
        .BASE_ADDR   (32'h0000_0100),
        .ADDR_MASK   (32'hFFFF_FFC0),
        .WAIT_CYCLES (WAIT_CYC),
        .ID_VALUE    (ID),
        .STAT_W      (STAT_W)
    ) dut (
        .up_clk     (up_clk),
        .up_rst_n   (up_rst_n),
        .up_wr      (up_wr),
        .up_rd      (up_rd),
        .up_addr    (up_addr),
        .up_data_wr (up_data_wr),
        .up_data_rd (up_data_rd),
        .up_wait    (up_wait),
        .ctrl_out   (ctrl_out),
        .status_in  (status_in),
        .irq        (irq)
    );

    always #5 up_clk = ~up_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first cycle with up_wait low.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd, input int exp_wait,
                          input logic [STAT_W-1:0] pulse, input int drop_at, input string name);
        int n;
        logic [31:0] exp;
        up_wr = wr;
        up_rd = rd;
        up_addr = addr;
        up_data_wr = data;
        if (rd && exp_wait > 0) sb_q.push_back(exp_rd);
        if (exp_wait > 0) m_acc++;
        @(negedge up_clk);
        up_wr = 1'b0;
        up_rd = 1'b0;
        n = 0;
        while (up_wait === 1'b1 && n < 20) begin
            n++;
            if (n == WAIT_CYC) status_in = pulse;
            if (n == drop_at) begin
                up_rd = 1'b1;
                up_addr = (drop_at == 1) ? 32'h0000_0200 : 32'h0000_0100;
            end
            @(negedge up_clk);
            status_in = '0;
            up_rd = 1'b0;
        end
        check({name, "_wait"}, 32'(n), 32'(exp_wait));
        if (rd && exp_wait > 0 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({name, "_data"}, up_data_rd, exp);
        end
    endtask

    task automatic pulse_status(input logic [STAT_W-1:0] mask);
        status_in = mask;
        @(negedge up_clk);
        status_in = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h104, 32'hA5A5_5A5A, 32'h0,         2, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h104, 32'h0,         32'hA5A5_5A5A, 2, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h110, 32'h0,         32'd2,         2, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h100, 32'h0,         ID,            2, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 32'h108, 32'hFFFF_1234, 32'h0,         2, 8'h34};
        vecs[5]  = '{1'b0, 1'b1, 32'h108, 32'h0,         32'h0000_1234, 2, 8'h34};
        vecs[6]  = '{1'b0, 1'b1, 32'h124, 32'h0,         MISS,          2, 8'h34};
        vecs[7]  = '{1'b1, 1'b0, 32'h124, 32'h1111_1111, 32'h0,         2, 8'h34};
        vecs[8]  = '{1'b1, 1'b0, 32'h100, 32'h0,         32'h0,         2, 8'h34};
        vecs[9]  = '{1'b0, 1'b1, 32'h100, 32'h0,         ID,            2, 8'h34};
        vecs[10] = '{1'b0, 1'b1, 32'h200, 32'h0,         32'h0,         0, 8'h34};
        vecs[11] = '{1'b0, 1'b1, 32'h114, 32'h0,         32'd0,         2, 8'h34};
        vecs[12] = '{1'b0, 1'b1, 32'h110, 32'h0,         32'd11,        2, 8'h34};
        vecs[13] = '{1'b0, 1'b1, 32'h13C, 32'h0,         MISS,          2, 8'h34};
        vecs[14] = '{1'b0, 1'b1, 32'h140, 32'h0,         32'h0,         0, 8'h34};
        vecs[15] = '{1'b1, 1'b0, 32'h204, 32'h0BAD_F00D, 32'h0,         0, 8'h34};
        vecs[16] = '{1'b0, 1'b1, 32'h104, 32'h0,         32'hA5A5_5A5A, 2, 8'h34};
        vecs[17] = '{1'b1, 1'b0, 32'h108, 32'h0,         32'h0,         2, 8'h00};

        repeat (3) @(negedge up_clk);
        check("rst_wait", 32'(up_wait), 32'h0);
        check("rst_data", up_data_rd, 32'h0);
        check("rst_ctrl", 32'(ctrl_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        up_rst_n = 1'b1;
        m_acc = 0;
        @(negedge up_clk);

        for (int i = 0; i < 18; i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
                   vecs[i].exp_wait, '0, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
        end

        // Sticky status and irq timing.
        pulse_status(8'h08);
        check("irq_masked", 32'(irq), 32'h0);
        access(1'b1, 1'b0, 32'h108, 32'h0000_0800, 32'h0, 2, '0, 0, "ctrl_irq_en");
        check("irq_lag", 32'(irq), 32'h0);
        @(negedge up_clk);
        check("irq_set", 32'(irq), 32'h1);
        access(1'b0, 1'b1, 32'h10C, 32'h0, 32'h8, 2, '0, 0, "stat_rd8");
        access(1'b1, 1'b0, 32'h10C, 32'h0000_0008, 32'h0, 2, '0, 0, "stat_w1c8");
        @(negedge up_clk);
        check("irq_clr", 32'(irq), 32'h0);
        access(1'b0, 1'b1, 32'h10C, 32'h0, 32'h0, 2, '0, 0, "stat_rd0");
        pulse_status(8'h04);
        access(1'b1, 1'b0, 32'h10C, 32'h0000_0004, 32'h0, 2, 8'h04, 0, "stat_setwins");
        access(1'b0, 1'b1, 32'h10C, 32'h0, 32'h4, 2, 8'h01, 0, "stat_preupd");
        access(1'b0, 1'b1, 32'h10C, 32'h0, 32'h5, 2, '0, 0, "stat_rd5");
        access(1'b1, 1'b0, 32'h10C, 32'h0000_00FF, 32'h0, 2, '0, 0, "stat_w1cff");
        access(1'b0, 1'b1, 32'h10C, 32'h0, 32'h0, 2, '0, 0, "stat_rd0b");

        // Drops while busy, back-to-back acceptance, rejected dual strobes.
        access(1'b0, 1'b1, 32'h104, 32'h0, 32'hA5A5_5A5A, 2, '0, 1, "busy_drop");
        access(1'b0, 1'b1, 32'h114, 32'h0, 32'd1, 2, '0, 0, "drop_rd1");
        access(1'b1, 1'b1, 32'h104, 32'h0, 32'h0, 0, '0, 0, "dual_in");
        access(1'b1, 1'b1, 32'h204, 32'h0, 32'h0, 0, '0, 0, "dual_out");
        access(1'b0, 1'b1, 32'h114, 32'h0, 32'd2, 2, '0, 2, "drop_commit_edge");
        access(1'b0, 1'b1, 32'h114, 32'h0, 32'd3, 2, '0, 0, "drop_rd3");
        access(1'b0, 1'b1, 32'h110, 32'h0, 32'(m_acc), 2, '0, 0, "acc_model");

        // Reset in the middle of a SCRATCH write.
        pulse_status(8'h01);
        access(1'b1, 1'b0, 32'h108, 32'h0000_01AA, 32'h0, 2, '0, 0, "ctrl_1aa");
        @(negedge up_clk);
        check("irq_pre_rst", 32'(irq), 32'h1);
        check("ctrl_pre_rst", 32'(ctrl_out), 32'hAA);
        access(1'b0, 1'b1, 32'h104, 32'h0, 32'hA5A5_5A5A, 2, '0, 0, "scr_pre_rst");
        up_wr = 1'b1;
        up_addr = 32'h104;
        up_data_wr = 32'h1234_5678;
        @(negedge up_clk);
        up_wr = 1'b0;
        check("busy_before_rst", 32'(up_wait), 32'h1);
        #2;
        up_rst_n = 1'b0;
        #1;
        check("rst_mid_wait", 32'(up_wait), 32'h0);
        check("rst_mid_data", up_data_rd, 32'h0);
        check("rst_mid_ctrl", 32'(ctrl_out), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        @(negedge up_clk);
        @(negedge up_clk);
        up_rst_n = 1'b1;
        m_acc = 0;
        sb_q.delete();
        access(1'b0, 1'b1, 32'h104, 32'h0, 32'h0, 2, '0, 0, "scr_after_rst");
        access(1'b0, 1'b1, 32'h110, 32'h0, 32'(m_acc), 2, '0, 0, "acc_after_rst");
        access(1'b0, 1'b1, 32'h114, 32'h0, 32'd0, 2, '0, 0, "drop_after_rst");

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
